fadd_align_stage: RTL

FADD_ALIGN_STAGE -- requirements
Module: fadd_align_stage

---
 rtl/fp_pkg.sv | 41 ++++
 rtl/fp_align_shifter.sv | 32 +++
 rtl/fadd_align_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision adder types: the aligned-operand record handed from
// the alignment stage to the mantissa adder, plus field widths and constants.
package fp_pkg;

    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam int MANT_EXT_W = 28;

    localparam logic [31:0]      QNAN      = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;
    localparam logic [EXP_W-1:0] FAR_SHIFT = 8'd27;

    typedef enum logic [1:0] {
        SPEC_NORMAL = 2'b00,
        SPEC_NAN    = 2'b01,
        SPEC_INF    = 2'b10
    } special_e;

    typedef struct packed {
        logic                  sign;
        logic                  eff_sub;
        logic [EXP_W-1:0]      exp;
        logic [MANT_EXT_W-1:0] ma;
        logic [MANT_EXT_W-1:0] mb;
        special_e              special;
        logic [31:0]           spec_val;
    } fadd_align_t;

    // {0, hidden, frac, guard/round/sticky}; a zero exponent flushes to zero.
    function automatic logic [MANT_EXT_W-1:0] ext_mant(
        input logic [EXP_W-1:0]  e,
        input logic [FRAC_W-1:0] f
    );
        if (e == '0) begin
            ext_mant = '0;
        end else begin
            ext_mant = {1'b0, 1'b1, f, 3'b000};
        end
    endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational sticky right-shifter for the smaller operand's extended mantissa.
module fp_align_shifter
    import fp_pkg::*;
(
    input  logic [MANT_EXT_W-1:0] i_mant,
    input  logic [EXP_W-1:0]      i_shift,
    output logic [MANT_EXT_W-1:0] o_mant
);

    logic                  w_far;
    logic [MANT_EXT_W-1:0] w_shifted;
    logic [MANT_EXT_W-1:0] w_lost_mask;
    logic                  w_sticky;

    function automatic logic [MANT_EXT_W-1:0] far_result(input logic [MANT_EXT_W-1:0] m);
        far_result = {{(MANT_EXT_W-1){1'b0}}, |m};
    endfunction

    always_comb begin
        w_far       = (i_shift >= FAR_SHIFT);
        // Below FAR_SHIFT the low five bits carry the full shift amount.
        w_shifted   = i_mant >> i_shift[4:0];
        w_lost_mask = ~({MANT_EXT_W{1'b1}} << i_shift[4:0]);
        w_sticky    = |(i_mant & w_lost_mask);
        if (w_far) begin
            o_mant = far_result(i_mant);
        end else begin
            o_mant = {w_shifted[MANT_EXT_W-1:1], w_shifted[0] | w_sticky};
        end
    end

endmodule

// File: rtl/fadd_align_stage.sv
// FP add alignment stage: orders operands by magnitude, aligns the smaller
// mantissa with sticky, classifies NaN/Inf, and buffers records in a skid pair.
module fadd_align_stage
    import fp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           a,
    input  logic [31:0]           b,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic                  out_eff_sub,
    output logic [EXP_W-1:0]      out_exp,
    output logic [MANT_EXT_W-1:0] out_ma,
    output logic [MANT_EXT_W-1:0] out_mb,
    output logic [1:0]            out_special,
    output logic [31:0]           out_spec_val
);

    logic                  w_a_larger;
    logic [31:0]           w_big;
    logic [31:0]           w_small;
    logic [EXP_W-1:0]      w_shift;
    logic [MANT_EXT_W-1:0] w_mb_pre;
    logic [MANT_EXT_W-1:0] w_mb;
    logic                  w_a_inf;
    logic                  w_b_inf;
    logic                  w_a_nan;
    logic                  w_b_nan;
    fadd_align_t           w_rec;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_skid_vld_nxt;

    fadd_align_t           r_out;
    fadd_align_t           r_skid;
    logic                  r_out_vld;
    logic                  r_skid_vld;
    logic                  r_in_ready;

    function automatic logic is_inf(input logic [31:0] x);
        is_inf = (x[30:23] == EXP_MAX) && (x[22:0] == '0);
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        is_nan = (x[30:23] == EXP_MAX) && (x[22:0] != '0);
    endfunction

    // ---- operand ordering: ties on {exp, frac} keep a as the larger ----
    always_comb begin
        w_a_larger = (a[30:0] >= b[30:0]);
        w_big      = w_a_larger ? a : b;
        w_small    = w_a_larger ? b : a;
        w_shift    = w_big[30:23] - w_small[30:23];
        w_mb_pre   = ext_mant(w_small[30:23], w_small[22:0]);
    end

    fp_align_shifter u_shifter (
        .i_mant  (w_mb_pre),
        .i_shift (w_shift),
        .o_mant  (w_mb)
    );

    // ---- special-value classification and record assembly ----
    always_comb begin
        w_a_inf = is_inf(a);
        w_b_inf = is_inf(b);
        w_a_nan = is_nan(a);
        w_b_nan = is_nan(b);

        w_rec          = '0;
        w_rec.sign     = w_big[31];
        w_rec.eff_sub  = a[31] ^ b[31];
        w_rec.exp      = w_big[30:23];
        w_rec.ma       = ext_mant(w_big[30:23], w_big[22:0]);
        w_rec.mb       = w_mb;
        w_rec.special  = SPEC_NORMAL;
        w_rec.spec_val = '0;

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[31] != b[31]))) begin
            w_rec.special  = SPEC_NAN;
            w_rec.spec_val = QNAN;
        end else if (w_a_inf) begin
            w_rec.special  = SPEC_INF;
            w_rec.spec_val = {a[31], EXP_MAX, {FRAC_W{1'b0}}};
        end else if (w_b_inf) begin
            w_rec.special  = SPEC_INF;
            w_rec.spec_val = {b[31], EXP_MAX, {FRAC_W{1'b0}}};
        end
    end

    // ---- skid buffer handshake ----
    // The skid entry only fills while the output entry is stalled, so
    // "skid occupied" is the same as "both entries occupied".
    always_comb begin
        w_push = in_valid && r_in_ready;
        w_pop  = r_out_vld && out_ready;
        if (!r_out_vld || w_pop) begin
            w_skid_vld_nxt = 1'b0;
        end else begin
            w_skid_vld_nxt = r_skid_vld || w_push;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out      <= '0;
            r_skid     <= '0;
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= !w_skid_vld_nxt;
            if (!r_out_vld || w_pop) begin
                if (r_skid_vld) begin
                    r_out      <= r_skid;
                    r_out_vld  <= 1'b1;
                    r_skid_vld <= 1'b0;
                end else if (w_push) begin
                    r_out     <= w_rec;
                    r_out_vld <= 1'b1;
                end else begin
                    r_out_vld <= 1'b0;
                end
            end else if (w_push) begin
                r_skid     <= w_rec;
                r_skid_vld <= 1'b1;
            end
        end
    end

    // ---- output stage ----
    always_comb begin
        in_ready     = r_in_ready;
        out_valid    = r_out_vld;
        out_sign     = r_out.sign;
        out_eff_sub  = r_out.eff_sub;
        out_exp      = r_out.exp;
        out_ma       = r_out.ma;
        out_mb       = r_out.mb;
        out_special  = r_out.special;
        out_spec_val = r_out.spec_val;
    end

endmodule
